// File: rtl/aud_clip_ctrl.sv
// Multi-slot record/playback controller between the key debouncers, the I2S
// recorder/player and a single asynchronous SRAM partitioned into N_SLOTS clips.
module aud_clip_ctrl #(
  parameter int ADDR_W  = 20,
  parameter int DATA_W  = 16,
  parameter int N_SLOTS = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_key_stop,
  input  logic                       i_key_play,
  input  logic                       i_key_rec,
  input  logic [$clog2(N_SLOTS)-1:0] i_slot,
  input  logic                       i_loop,
  input  logic                       i_sample_stb,
  input  logic [DATA_W-1:0]          i_rec_data,
  output logic [ADDR_W-1:0]          o_sram_addr,
  output logic                       o_sram_we,
  output logic [DATA_W-1:0]          o_sram_wdata,
  input  logic [DATA_W-1:0]          i_sram_rdata,
  output logic [DATA_W-1:0]          o_play_data,
  output logic                       o_play_valid,
  output logic [2:0]                 o_state,
  output logic                       o_done
);

  localparam int SLOT_BITS = $clog2(N_SLOTS);
  localparam int SLOT_W    = ADDR_W - SLOT_BITS;

  localparam logic [SLOT_W-1:0] OFF_ONE = SLOT_W'(1);
  localparam logic [SLOT_W-1:0] OFF_MAX = '1;
  localparam logic [SLOT_W:0]   LEN_ONE = (SLOT_W+1)'(1);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_RECD       = 3'd1,
    ST_RECD_PAUSE = 3'd2,
    ST_PLAY       = 3'd3,
    ST_PLAY_PAUSE = 3'd4
  } state_t;

  state_t               state, state_nxt;
  logic [SLOT_BITS-1:0] slot, slot_nxt;
  logic [SLOT_W-1:0]    offset, offset_nxt;
  logic [SLOT_W:0]      len [N_SLOTS];
  logic                 wr_en, rd_en, len_clr, done_nxt;
  logic                 play_last;

  logic [ADDR_W-1:0]    sram_addr_p1;
  logic                 sram_we_p1;
  logic [DATA_W-1:0]    sram_wdata_p1;
  logic [DATA_W-1:0]    play_data_p1;
  logic                 play_vld_p1;
  logic                 done_p1;

  assign play_last = (({1'b0, offset} + LEN_ONE) == len[slot]);

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Any key in a cycle swallows that cycle's sample strobe.
  always_comb begin
    state_nxt  = state;
    slot_nxt   = slot;
    offset_nxt = offset;
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    len_clr    = 1'b0;
    done_nxt   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_key_stop) begin
          state_nxt = ST_IDLE;
        end else if (i_key_rec) begin
          state_nxt  = ST_RECD;
          slot_nxt   = i_slot;
          offset_nxt = '0;
          len_clr    = 1'b1;
        end else if (i_key_play && (len[i_slot] != '0)) begin
          state_nxt  = ST_PLAY;
          slot_nxt   = i_slot;
          offset_nxt = '0;
        end
      end
      ST_RECD: begin
        if (i_key_stop) begin
          state_nxt = ST_IDLE;
        end else if (i_key_rec) begin
          state_nxt = ST_RECD_PAUSE;
        end else if (!i_key_play && i_sample_stb) begin
          wr_en      = 1'b1;
          offset_nxt = offset + OFF_ONE;
          if (offset == OFF_MAX) begin
            state_nxt = ST_IDLE;
            done_nxt  = 1'b1;
          end
        end
      end
      ST_RECD_PAUSE: begin
        if (i_key_stop)     state_nxt = ST_IDLE;
        else if (i_key_rec) state_nxt = ST_RECD;
      end
      ST_PLAY: begin
        if (i_key_stop) begin
          state_nxt = ST_IDLE;
        end else if (i_key_play) begin
          state_nxt = ST_PLAY_PAUSE;
        end else if (!i_key_rec && i_sample_stb) begin
          rd_en = 1'b1;
          if (play_last) begin
            if (i_loop) begin
              offset_nxt = '0;
            end else begin
              state_nxt = ST_IDLE;
              done_nxt  = 1'b1;
            end
          end else begin
            offset_nxt = offset + OFF_ONE;
          end
        end
      end
      ST_PLAY_PAUSE: begin
        if (i_key_stop)      state_nxt = ST_IDLE;
        else if (i_key_play) state_nxt = ST_PLAY;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // p1 stage: registered SRAM strobe/address/data and player outputs.
  // Outside a write cycle the address tracks {slot, offset} so playback
  // reads always see the current offset on the asynchronous SRAM.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      slot          <= '0;
      offset        <= '0;
      for (int s = 0; s < N_SLOTS; s++) len[s] <= '0;
      sram_addr_p1  <= '0;
      sram_we_p1    <= 1'b0;
      sram_wdata_p1 <= '0;
      play_data_p1  <= '0;
      play_vld_p1   <= 1'b0;
      done_p1       <= 1'b0;
    end else begin
      slot        <= slot_nxt;
      offset      <= offset_nxt;
      sram_we_p1  <= wr_en;
      play_vld_p1 <= rd_en;
      done_p1     <= done_nxt;
      if (len_clr) len[slot_nxt] <= '0;
      if (wr_en) begin
        sram_addr_p1  <= {slot, offset};
        sram_wdata_p1 <= i_rec_data;
        len[slot]     <= {1'b0, offset} + LEN_ONE;
      end else begin
        sram_addr_p1  <= {slot_nxt, offset_nxt};
      end
      if (rd_en)                      play_data_p1 <= i_sram_rdata;
      else if (state_nxt != ST_PLAY)  play_data_p1 <= '0;
    end
  end

  assign o_sram_addr  = sram_addr_p1;
  assign o_sram_we    = sram_we_p1;
  assign o_sram_wdata = sram_wdata_p1;
  assign o_play_data  = play_data_p1;
  assign o_play_valid = play_vld_p1;
  assign o_done       = done_p1;
  assign o_state      = state;

endmodule

// File: tb/tb_aud_clip_ctrl.sv
// Directed bench for aud_clip_ctrl: default 20-bit instance with an SRAM model,
// plus a 6-bit-address instance for the slot-full boundary.
module tb_aud_clip_ctrl;

  logic        clk = 1'b0;
  logic        rst, key_stop, key_play, key_rec, loop, stb;
  logic [1:0]  slot;
  logic [15:0] rec_data;

  logic [19:0] sram_addr;
  logic        sram_we;
  logic [15:0] sram_wdata, sram_rdata, play_data;
  logic        play_valid, done;
  logic [2:0]  state;

  logic [5:0]  s_addr;
  logic        s_we, s_valid, s_done;
  logic [15:0] s_wdata, s_play_data;
  logic [2:0]  s_state;

  logic [15:0] mem [0:255];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  aud_clip_ctrl #(.ADDR_W(20), .DATA_W(16), .N_SLOTS(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_key_stop(key_stop), .i_key_play(key_play),
    .i_key_rec(key_rec), .i_slot(slot), .i_loop(loop), .i_sample_stb(stb),
    .i_rec_data(rec_data), .o_sram_addr(sram_addr), .o_sram_we(sram_we),
    .o_sram_wdata(sram_wdata), .i_sram_rdata(sram_rdata), .o_play_data(play_data),
    .o_play_valid(play_valid), .o_state(state), .o_done(done)
  );

  aud_clip_ctrl #(.ADDR_W(6), .DATA_W(16), .N_SLOTS(4)) dut_s (
    .i_clk(clk), .i_rst(rst), .i_key_stop(key_stop), .i_key_play(key_play),
    .i_key_rec(key_rec), .i_slot(slot), .i_loop(loop), .i_sample_stb(stb),
    .i_rec_data(rec_data), .o_sram_addr(s_addr), .o_sram_we(s_we),
    .o_sram_wdata(s_wdata), .i_sram_rdata(sram_rdata), .o_play_data(s_play_data),
    .o_play_valid(s_valid), .o_state(s_state), .o_done(s_done)
  );

  // Asynchronous-read SRAM model; only slot bits and low offset bits are stored.
  always @(posedge clk) if (sram_we) mem[{sram_addr[19:18], sram_addr[5:0]}] <= sram_wdata;
  assign sram_rdata = mem[{sram_addr[19:18], sram_addr[5:0]}];

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    key_stop = 0; key_play = 0; key_rec = 0; stb = 0;
  endtask

  task automatic test_reset();
    rst = 1; idle_inputs(); loop = 0; slot = 0; rec_data = 0;
    cyc(); cyc();
    rst = 0;
    n_checks++; if (state !== 3'd0) begin n_errors++; $display("FAIL reset_state got=%0d exp=0", state); end
    n_checks++; if ({sram_we, play_valid, done} !== 3'b000) begin n_errors++; $display("FAIL reset_strobes got=%b exp=000", {sram_we, play_valid, done}); end
    n_checks++; if (sram_addr !== 20'h0 || play_data !== 16'h0 || sram_wdata !== 16'h0) begin
      n_errors++; $display("FAIL reset_data addr=%0h pdata=%0h wdata=%0h exp=0", sram_addr, play_data, sram_wdata); end
  endtask

  task automatic test_record();
    logic [19:0] ea;
    slot = 2; key_rec = 1; cyc(); key_rec = 0;
    n_checks++; if (state !== 3'd1) begin n_errors++; $display("FAIL rec_start_state got=%0d exp=1", state); end
    for (int k = 0; k < 5; k++) begin
      slot = 2'(k);
      ea = 20'h80000 + 20'(k);
      rec_data = 16'h10 + 16'(k); stb = 1; cyc(); stb = 0;
      n_checks++; if (sram_we !== 1'b1 || sram_addr !== ea || sram_wdata !== 16'h10 + 16'(k)) begin
        n_errors++; $display("FAIL rec_write%0d we=%b addr=%0h data=%0h exp we=1 addr=%0h data=%0h", k, sram_we, sram_addr, sram_wdata, ea, 16'h10 + 16'(k)); end
      cyc();
      n_checks++; if (sram_we !== 1'b0) begin n_errors++; $display("FAIL rec_we_gap%0d got=%b exp=0", k, sram_we); end
    end
    key_stop = 1; cyc(); key_stop = 0;
    n_checks++; if (state !== 3'd0) begin n_errors++; $display("FAIL rec_stop_state got=%0d exp=0", state); end
  endtask

  task automatic test_play_once();
    loop = 0; slot = 2; key_play = 1; cyc(); key_play = 0;
    n_checks++; if (state !== 3'd3 || sram_addr !== 20'h80000) begin
      n_errors++; $display("FAIL play_start state=%0d addr=%0h exp 3/80000", state, sram_addr); end
    for (int k = 0; k < 5; k++) begin
      stb = 1; cyc(); stb = 0;
      n_checks++; if (play_valid !== 1'b1 || play_data !== 16'h10 + 16'(k) || done !== (k == 4)) begin
        n_errors++; $display("FAIL play_sample%0d valid=%b data=%0h done=%b exp 1/%0h/%b", k, play_valid, play_data, done, 16'h10 + 16'(k), (k == 4)); end
      cyc();
      n_checks++; if (play_valid !== 1'b0 || done !== 1'b0) begin n_errors++; $display("FAIL play_gap%0d valid=%b done=%b exp 0/0", k, play_valid, done); end
    end
    n_checks++; if (state !== 3'd0 || play_data !== 16'h0) begin
      n_errors++; $display("FAIL play_end state=%0d data=%0h exp 0/0", state, play_data); end
  endtask

  task automatic test_play_loop();
    logic [15:0] ed;
    loop = 1; slot = 2; key_play = 1; cyc(); key_play = 0;
    for (int k = 0; k < 12; k++) begin
      ed = 16'h10 + 16'(k % 5);
      stb = 1; cyc(); stb = 0;
      n_checks++; if (play_valid !== 1'b1 || play_data !== ed || done !== 1'b0) begin
        n_errors++; $display("FAIL loop_sample%0d valid=%b data=%0h done=%b exp 1/%0h/0", k, play_valid, play_data, done, ed); end
      cyc();
    end
    n_checks++; if (state !== 3'd3) begin n_errors++; $display("FAIL loop_still_playing got=%0d exp=3", state); end
    key_stop = 1; cyc(); key_stop = 0;
    n_checks++; if (state !== 3'd0 || play_data !== 16'h0 || done !== 1'b0) begin
      n_errors++; $display("FAIL loop_stop state=%0d data=%0h done=%b exp 0/0/0", state, play_data, done); end
    loop = 0;
  endtask

  task automatic test_pause_resume();
    slot = 0; key_rec = 1; cyc(); key_rec = 0;
    for (int k = 0; k < 2; k++) begin rec_data = 16'h30 + 16'(k); stb = 1; cyc(); stb = 0; cyc(); end
    rec_data = 16'hEE; key_rec = 1; stb = 1; cyc(); key_rec = 0; stb = 0;
    n_checks++; if (state !== 3'd2 || sram_we !== 1'b0) begin
      n_errors++; $display("FAIL pause_key_beats_stb state=%0d we=%b exp 2/0", state, sram_we); end
    stb = 1; cyc(); stb = 0;
    n_checks++; if (sram_we !== 1'b0 || state !== 3'd2) begin
      n_errors++; $display("FAIL pause_stb_ignored we=%b state=%0d exp 0/2", sram_we, state); end
    key_rec = 1; cyc(); key_rec = 0;
    n_checks++; if (state !== 3'd1) begin n_errors++; $display("FAIL resume_state got=%0d exp=1", state); end
    rec_data = 16'h33; stb = 1; cyc(); stb = 0;
    n_checks++; if (sram_we !== 1'b1 || sram_addr !== 20'h00002 || sram_wdata !== 16'h33) begin
      n_errors++; $display("FAIL resume_write we=%b addr=%0h data=%0h exp 1/2/33", sram_we, sram_addr, sram_wdata); end
    key_stop = 1; cyc(); key_stop = 0;
    key_play = 1; cyc(); key_play = 0;
    key_play = 1; cyc(); key_play = 0;
    n_checks++; if (state !== 3'd4) begin n_errors++; $display("FAIL play_pause_state got=%0d exp=4", state); end
    stb = 1; cyc(); stb = 0;
    n_checks++; if (play_valid !== 1'b0 || play_data !== 16'h0) begin
      n_errors++; $display("FAIL play_pause_stb valid=%b data=%0h exp 0/0", play_valid, play_data); end
    key_play = 1; cyc(); key_play = 0;
    stb = 1; cyc(); stb = 0;
    n_checks++; if (play_valid !== 1'b1 || play_data !== 16'h30) begin
      n_errors++; $display("FAIL play_resume valid=%b data=%0h exp 1/30", play_valid, play_data); end
    key_stop = 1; key_play = 1; cyc(); key_stop = 0; key_play = 0;
    n_checks++; if (state !== 3'd0 || play_data !== 16'h0) begin
      n_errors++; $display("FAIL stop_beats_play state=%0d data=%0h exp 0/0", state, play_data); end
  endtask

  task automatic test_empty_and_reset();
    slot = 1; key_play = 1; cyc(); key_play = 0;
    n_checks++; if (state !== 3'd0 || play_valid !== 1'b0 || done !== 1'b0) begin
      n_errors++; $display("FAIL empty_slot state=%0d valid=%b done=%b exp 0/0/0", state, play_valid, done); end
    stb = 1; cyc(); stb = 0;
    n_checks++; if (play_valid !== 1'b0 || done !== 1'b0) begin
      n_errors++; $display("FAIL empty_slot_stb valid=%b done=%b exp 0/0", play_valid, done); end
    slot = 3; key_rec = 1; cyc(); key_rec = 0;
    rec_data = 16'h77; stb = 1; cyc(); stb = 0;
    rst = 1; cyc(); rst = 0;
    n_checks++; if (state !== 3'd0 || sram_we !== 1'b0 || sram_addr !== 20'h0) begin
      n_errors++; $display("FAIL midrec_reset state=%0d we=%b addr=%0h exp 0/0/0", state, sram_we, sram_addr); end
    slot = 2; key_play = 1; cyc(); key_play = 0;
    n_checks++; if (state !== 3'd0) begin n_errors++; $display("FAIL len_cleared_by_reset state=%0d exp=0", state); end
  endtask

  task automatic test_slot_full();
    rst = 1; cyc(); rst = 0;
    slot = 1; key_rec = 1; cyc(); key_rec = 0;
    for (int k = 0; k < 16; k++) begin
      rec_data = 16'h100 + 16'(k); stb = 1; cyc(); stb = 0;
      n_checks++; if (s_we !== 1'b1 || s_addr !== 6'(16 + k) || s_done !== (k == 15)) begin
        n_errors++; $display("FAIL full_write%0d we=%b addr=%0h done=%b exp 1/%0h/%b", k, s_we, s_addr, s_done, 6'(16 + k), (k == 15)); end
      cyc();
    end
    n_checks++; if (s_state !== 3'd0 || s_done !== 1'b0) begin
      n_errors++; $display("FAIL full_idle state=%0d done=%b exp 0/0", s_state, s_done); end
    stb = 1; cyc(); stb = 0;
    n_checks++; if (s_we !== 1'b0 || s_state !== 3'd0) begin
      n_errors++; $display("FAIL full_17th_stb we=%b state=%0d exp 0/0", s_we, s_state); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0;
    test_reset();
    test_record();
    test_play_once();
    test_play_loop();
    test_pause_resume();
    test_empty_and_reset();
    test_slot_full();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
